// File: rtl/smg_scan_driver.sv
// smg_scan_driver
//   Multiplexed seven-segment scan driver. Packed hex nibbles and per-digit
//   decimal points are captured on Load. They are moved into the displayed
//   (shadow) copy only at a frame boundary, so a frame never mixes old and
//   new digits. Also provides leading-zero blanking and PWM brightness.
//
// Ports
//   CLK         system clock
//   RSTn        asynchronous active-low reset
//   Number_Sig  hex nibbles, [3:0] = digit 0 (rightmost)
//   Dp_Sig      decimal point per digit, bit i = digit i
//   Load        1-cycle strobe capturing Number_Sig/Dp_Sig
//   Lz_En       1: blank leading zeros
//   Bright      duty level, 0 = 1/2**BRIGHT_W, max = 100%
//   SMG_Data    segments {dp,g,f,e,d,c,b,a}, registered
//   Scan_Sig    one-hot digit select, registered
//   Frame_Done  1-cycle pulse after the last digit slot ends
module smg_scan_driver #(
    parameter int DIGITS      = 6,
    parameter int SLOT_CYC    = 50000,
    parameter int BRIGHT_W    = 4,
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit SEL_ACT_LOW = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic [4*DIGITS-1:0]   Number_Sig,
    input  logic [DIGITS-1:0]     Dp_Sig,
    input  logic                  Load,
    input  logic                  Lz_En,
    input  logic [BRIGHT_W-1:0]   Bright,
    output logic [7:0]            SMG_Data,
    output logic [DIGITS-1:0]     Scan_Sig,
    output logic                  Frame_Done
);

    localparam int CW   = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
    localparam int IW   = $clog2(DIGITS);
    localparam int STEP = SLOT_CYC >> BRIGHT_W;

    localparam logic [CW-1:0]     CNT_LAST = CW'(SLOT_CYC - 1);
    localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
    localparam logic [7:0]        SEG_INV  = {8{SEG_ACT_LOW}};
    localparam logic [DIGITS-1:0] SEL_INV  = {DIGITS{SEL_ACT_LOW}};

    logic [CW-1:0]         count;
    logic [IW-1:0]         idx;
    logic                  slot_end;
    logic                  frame_end;

    logic [4*DIGITS-1:0]   stage_num;
    logic [DIGITS-1:0]     stage_dp;
    logic                  pending;
    logic [4*DIGITS-1:0]   shadow_num;
    logic [DIGITS-1:0]     shadow_dp;

    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_blank;
    logic [DIGITS-1:0]     blank_mask;
    logic                  lead;
    logic [6:0]            seg_raw;
    logic                  enabled;
    logic [7:0]            seg_nxt;
    logic [DIGITS-1:0]     sel_nxt;

    assign slot_end  = (count == CNT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    // slot timer and digit index
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            count <= '0;
            idx   <= '0;
        end else if (slot_end) begin
            count <= '0;
            idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            count <= count + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            Frame_Done <= 1'b0;
        end else begin
            Frame_Done <= frame_end;
        end
    end

    // Staging/shadow update. A Load landing exactly on frame_end goes straight
    // to the shadow so it is not delayed by a whole frame.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            stage_num  <= '0;
            stage_dp   <= '0;
            pending    <= 1'b0;
            shadow_num <= '0;
            shadow_dp  <= '0;
        end else if (Load && frame_end) begin
            stage_num  <= Number_Sig;
            stage_dp   <= Dp_Sig;
            shadow_num <= Number_Sig;
            shadow_dp  <= Dp_Sig;
            pending    <= 1'b0;
        end else if (Load) begin
            stage_num  <= Number_Sig;
            stage_dp   <= Dp_Sig;
            pending    <= 1'b1;
        end else if (frame_end && pending) begin
            shadow_num <= stage_num;
            shadow_dp  <= stage_dp;
            pending    <= 1'b0;
        end
    end

    // Leading-zero mask: walk down from the top digit while everything seen
    // so far is a zero nibble without dp. Digit 0 is never blanked.
    always_comb begin
        blank_mask = '0;
        lead       = Lz_En;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            lead          = lead && (shadow_num[i*4 +: 4] == 4'h0) && !shadow_dp[i];
            blank_mask[i] = lead;
        end
    end

    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_nib   = shadow_num[i*4 +: 4];
                cur_dp    = shadow_dp[i];
                cur_blank = blank_mask[i];
            end
        end
    end

    always_comb begin
        case (cur_nib)
            4'h0:    seg_raw = 7'h3F;
            4'h1:    seg_raw = 7'h06;
            4'h2:    seg_raw = 7'h5B;
            4'h3:    seg_raw = 7'h4F;
            4'h4:    seg_raw = 7'h66;
            4'h5:    seg_raw = 7'h6D;
            4'h6:    seg_raw = 7'h7D;
            4'h7:    seg_raw = 7'h07;
            4'h8:    seg_raw = 7'h7F;
            4'h9:    seg_raw = 7'h6F;
            4'hA:    seg_raw = 7'h77;
            4'hB:    seg_raw = 7'h7C;
            4'hC:    seg_raw = 7'h39;
            4'hD:    seg_raw = 7'h5E;
            4'hE:    seg_raw = 7'h79;
            default: seg_raw = 7'h71;
        endcase
    end

    // PWM: the slot is split into 2**BRIGHT_W sub-slots; the digit is lit
    // for sub-slots 0..Bright. The first cycle of each slot deselects all
    // digits so the previous digit's segments never ghost onto the new one.
    always_comb begin
        enabled = ((32'(count) / 32'(STEP)) <= 32'(Bright));
        seg_nxt = (enabled && !cur_blank) ? {cur_dp, seg_raw} : 8'h00;
        sel_nxt = '0;
        if (enabled && (count != '0)) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (idx == IW'(i)) begin
                    sel_nxt[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            SMG_Data <= SEG_INV;
            Scan_Sig <= SEL_INV;
        end else begin
            SMG_Data <= seg_nxt ^ SEG_INV;
            Scan_Sig <= sel_nxt ^ SEL_INV;
        end
    end

endmodule

// File: tb/tb_smg_scan_driver.sv
module tb_smg_scan_driver;

    localparam int DIGITS = 6;
    localparam int SLOT   = 16;
    localparam int BW     = 2;
    localparam int FRAME  = DIGITS * SLOT;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic [23:0] Number_Sig = '0;
    logic [5:0]  Dp_Sig = '0;
    logic        Load = 1'b0;
    logic        Lz_En = 1'b0;
    logic [1:0]  Bright = 2'd3;
    logic [7:0]  SMG_Data;
    logic [5:0]  Scan_Sig;
    logic        Frame_Done;

    smg_scan_driver #(
        .DIGITS(DIGITS), .SLOT_CYC(SLOT), .BRIGHT_W(BW),
        .SEG_ACT_LOW(1'b1), .SEL_ACT_LOW(1'b1)
    ) dut (
        .CLK(CLK), .RSTn(RSTn), .Number_Sig(Number_Sig), .Dp_Sig(Dp_Sig),
        .Load(Load), .Lz_En(Lz_En), .Bright(Bright),
        .SMG_Data(SMG_Data), .Scan_Sig(Scan_Sig), .Frame_Done(Frame_Done)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_bad = 0;

    logic [6:0] hex_tab [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // reference model: cycles since reset release, displayed and pending values
    int          cyc;
    logic [23:0] m_num, s_num, shown_num;
    logic [5:0]  m_dp, s_dp, shown_dp;
    bit          pend;
    logic [7:0]  exp_seg;
    logic [5:0]  exp_scan;
    logic        exp_fd;

    task automatic model_reset();
        cyc = 0; m_num = '0; m_dp = '0; s_num = '0; s_dp = '0; pend = 0;
    endtask

    task automatic tick();
        int cnt, dig;
        bit fe, en, blank;
        logic [3:0] nib;
        @(posedge CLK);
        cnt = cyc % SLOT;
        dig = (cyc / SLOT) % DIGITS;
        fe  = (cnt == SLOT - 1) && (dig == DIGITS - 1);
        en  = (cnt / (SLOT >> BW)) <= int'(Bright);
        nib = 4'(m_num >> (4 * dig));
        blank = Lz_En && (dig > 0) && ((m_num >> (4 * dig)) == 0) && ((m_dp >> dig) == 0);
        exp_seg  = (!en || blank) ? 8'hFF : ~{m_dp[dig], hex_tab[nib]};
        exp_scan = (!en || cnt == 0) ? 6'h3F : ~(6'b1 << dig);
        exp_fd   = fe;
        shown_num = m_num;
        shown_dp  = m_dp;
        if (Load && fe) begin
            m_num = Number_Sig; m_dp = Dp_Sig; s_num = Number_Sig; s_dp = Dp_Sig; pend = 0;
        end else begin
            if (fe && pend) begin
                m_num = s_num; m_dp = s_dp; pend = 0;
            end
            if (Load) begin
                s_num = Number_Sig; s_dp = Dp_Sig; pend = 1;
            end
        end
        cyc++;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RSTn = 1'b0;
        repeat (2) @(negedge CLK);
        n_vec++;
        if (SMG_Data !== 8'hFF) begin n_bad++; $display("FAIL reset_seg got=%h exp=ff", SMG_Data); end
        n_vec++;
        if (Scan_Sig !== 6'h3F) begin n_bad++; $display("FAIL reset_scan got=%h exp=3f", Scan_Sig); end
        n_vec++;
        if (Frame_Done !== 1'b0) begin n_bad++; $display("FAIL reset_fd got=%b exp=0", Frame_Done); end
        RSTn = 1'b1;
        model_reset();
    endtask

    task automatic test_basic();
        Bright = 2'd3; Lz_En = 1'b0;
        Number_Sig = 24'h123456; Dp_Sig = '0; Load = 1'b1;
        for (int k = 0; k < 2 * FRAME + 8; k++) begin
            tick();
            Load = 1'b0;
            n_vec++;
            if (SMG_Data !== exp_seg) begin n_bad++; $display("FAIL basic_seg cyc=%0d got=%h exp=%h", cyc, SMG_Data, exp_seg); end
            n_vec++;
            if (Scan_Sig !== exp_scan) begin n_bad++; $display("FAIL basic_scan cyc=%0d got=%h exp=%h", cyc, Scan_Sig, exp_scan); end
            n_vec++;
            if (Frame_Done !== exp_fd) begin n_bad++; $display("FAIL basic_fd cyc=%0d got=%b exp=%b", cyc, Frame_Done, exp_fd); end
            if (shown_num == 24'h123456 && Scan_Sig == 6'b111110) begin
                n_vec++;
                if (SMG_Data !== 8'h82) begin n_bad++; $display("FAIL basic_digit0 got=%h exp=82", SMG_Data); end
            end
            if (shown_num == 24'h123456 && Scan_Sig == 6'b011111) begin
                n_vec++;
                if (SMG_Data !== 8'hF9) begin n_bad++; $display("FAIL basic_digit5 got=%h exp=f9", SMG_Data); end
            end
        end
    endtask

    task automatic test_midframe_load();
        while (cyc % FRAME != 40) tick();
        Number_Sig = 24'h00000A; Dp_Sig = '0; Load = 1'b1;
        for (int k = 0; k < 2 * FRAME; k++) begin
            tick();
            Load = 1'b0;
            n_vec++;
            if (SMG_Data !== exp_seg) begin n_bad++; $display("FAIL mid_seg cyc=%0d got=%h exp=%h", cyc, SMG_Data, exp_seg); end
            n_vec++;
            if (Scan_Sig !== exp_scan) begin n_bad++; $display("FAIL mid_scan cyc=%0d got=%h exp=%h", cyc, Scan_Sig, exp_scan); end
            n_vec++;
            if (Frame_Done !== exp_fd) begin n_bad++; $display("FAIL mid_fd cyc=%0d got=%b exp=%b", cyc, Frame_Done, exp_fd); end
            if (shown_num == 24'h00000A && Scan_Sig == 6'b111110) begin
                n_vec++;
                if (SMG_Data !== 8'h88) begin n_bad++; $display("FAIL mid_digit0 got=%h exp=88", SMG_Data); end
            end
        end
    endtask

    task automatic test_lz();
        logic [5:0] dps [2] = '{6'b000000, 6'b010000};
        Lz_En = 1'b1;
        for (int p = 0; p < 2; p++) begin
            Number_Sig = 24'h000070; Dp_Sig = dps[p]; Load = 1'b1;
            for (int k = 0; k < 2 * FRAME; k++) begin
                tick();
                Load = 1'b0;
                n_vec++;
                if (SMG_Data !== exp_seg) begin n_bad++; $display("FAIL lz_seg cyc=%0d got=%h exp=%h", cyc, SMG_Data, exp_seg); end
                n_vec++;
                if (Scan_Sig !== exp_scan) begin n_bad++; $display("FAIL lz_scan cyc=%0d got=%h exp=%h", cyc, Scan_Sig, exp_scan); end
                n_vec++;
                if (Frame_Done !== exp_fd) begin n_bad++; $display("FAIL lz_fd cyc=%0d got=%b exp=%b", cyc, Frame_Done, exp_fd); end
                if (shown_num == 24'h000070 && shown_dp == dps[p]) begin
                    if (Scan_Sig == 6'b011111) begin
                        n_vec++;
                        if (SMG_Data !== 8'hFF) begin n_bad++; $display("FAIL lz_digit5 got=%h exp=ff", SMG_Data); end
                    end
                    if (Scan_Sig == 6'b111101) begin
                        n_vec++;
                        if (SMG_Data !== 8'hF8) begin n_bad++; $display("FAIL lz_digit1 got=%h exp=f8", SMG_Data); end
                    end
                    if (p == 1 && Scan_Sig == 6'b101111) begin
                        n_vec++;
                        if (SMG_Data !== 8'h40) begin n_bad++; $display("FAIL lz_digit4_dp got=%h exp=40", SMG_Data); end
                    end
                end
            end
        end
        Lz_En = 1'b0;
    endtask

    task automatic test_bright();
        int act [DIGITS];
        int want;
        for (int b = 0; b < 4; b += 3) begin
            Bright = 2'(b);
            want = (b + 1) * (SLOT >> BW) - 1;
            foreach (act[d]) act[d] = 0;
            for (int k = 0; k < FRAME; k++) begin
                tick();
                n_vec++;
                if (Scan_Sig !== exp_scan) begin n_bad++; $display("FAIL bright_scan cyc=%0d got=%h exp=%h", cyc, Scan_Sig, exp_scan); end
                n_vec++;
                if (SMG_Data !== exp_seg) begin n_bad++; $display("FAIL bright_seg cyc=%0d got=%h exp=%h", cyc, SMG_Data, exp_seg); end
                for (int d = 0; d < DIGITS; d++) if (Scan_Sig == ~(6'b1 << d)) act[d]++;
            end
            for (int d = 0; d < DIGITS; d++) begin
                n_vec++;
                if (act[d] !== want) begin n_bad++; $display("FAIL bright_duty b=%0d digit=%0d got=%0d exp=%0d", b, d, act[d], want); end
            end
        end
        Bright = 2'd3;
    endtask

    task automatic test_load_at_frame_end();
        logic [23:0] v;
        logic [5:0]  dp;
        int fd_cnt;
        Lz_En = 1'b0; Bright = 2'd3;
        while (cyc % FRAME != FRAME - 1) tick();
        v = 24'($urandom); dp = 6'($urandom);
        Number_Sig = v; Dp_Sig = dp; Load = 1'b1;
        tick();
        Load = 1'b0;
        tick();
        n_vec++;
        if (SMG_Data !== ~{dp[0], hex_tab[v[3:0]]}) begin
            n_bad++; $display("FAIL fe_load_guard got=%h exp=%h", SMG_Data, ~{dp[0], hex_tab[v[3:0]]});
        end
        tick();
        n_vec++;
        if (Scan_Sig !== 6'b111110 || SMG_Data !== ~{dp[0], hex_tab[v[3:0]]}) begin
            n_bad++; $display("FAIL fe_load_digit0 got=%h/%h exp=3e/%h", Scan_Sig, SMG_Data, ~{dp[0], hex_tab[v[3:0]]});
        end
        fd_cnt = 0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            tick();
            if (Frame_Done) fd_cnt++;
            n_vec++;
            if (SMG_Data !== exp_seg) begin n_bad++; $display("FAIL fe_seg cyc=%0d got=%h exp=%h", cyc, SMG_Data, exp_seg); end
            n_vec++;
            if (Frame_Done !== exp_fd) begin n_bad++; $display("FAIL fe_fd cyc=%0d got=%b exp=%b", cyc, Frame_Done, exp_fd); end
        end
        n_vec++;
        if (fd_cnt !== 2) begin n_bad++; $display("FAIL fe_pulse_count got=%0d exp=2", fd_cnt); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 900; k++) begin
            if (k % 50 == 0) Bright = 2'($urandom);
            if (k % 100 == 0) Lz_En = 1'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                Number_Sig = 24'($urandom) >> (4 * $urandom_range(0, 5));
                Dp_Sig = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'h00;
                Load = 1'b1;
            end
            tick();
            Load = 1'b0;
            n_vec++;
            if (SMG_Data !== exp_seg) begin n_bad++; $display("FAIL rand_seg cyc=%0d got=%h exp=%h", cyc, SMG_Data, exp_seg); end
            n_vec++;
            if (Scan_Sig !== exp_scan) begin n_bad++; $display("FAIL rand_scan cyc=%0d got=%h exp=%h", cyc, Scan_Sig, exp_scan); end
            n_vec++;
            if (Frame_Done !== exp_fd) begin n_bad++; $display("FAIL rand_fd cyc=%0d got=%b exp=%b", cyc, Frame_Done, exp_fd); end
        end
    endtask

    task automatic test_reset_midframe();
        Number_Sig = 24'h987654; Dp_Sig = 6'h3F; Load = 1'b1;
        tick();
        Load = 1'b0;
        while (!(cyc % SLOT == 7 && (cyc / SLOT) % DIGITS == 3)) tick();
        #3 RSTn = 1'b0;
        #1;
        n_vec++;
        if (SMG_Data !== 8'hFF) begin n_bad++; $display("FAIL rstmid_seg got=%h exp=ff", SMG_Data); end
        n_vec++;
        if (Scan_Sig !== 6'h3F) begin n_bad++; $display("FAIL rstmid_scan got=%h exp=3f", Scan_Sig); end
        n_vec++;
        if (Frame_Done !== 1'b0) begin n_bad++; $display("FAIL rstmid_fd got=%b exp=0", Frame_Done); end
        repeat (2) @(negedge CLK);
        RSTn = 1'b1;
        model_reset();
        Lz_En = 1'b1; Bright = 2'd3;
        for (int k = 0; k < FRAME + 4; k++) begin
            tick();
            n_vec++;
            if (SMG_Data !== exp_seg) begin n_bad++; $display("FAIL rstmid_post_seg cyc=%0d got=%h exp=%h", cyc, SMG_Data, exp_seg); end
            n_vec++;
            if (Scan_Sig !== exp_scan) begin n_bad++; $display("FAIL rstmid_post_scan cyc=%0d got=%h exp=%h", cyc, Scan_Sig, exp_scan); end
            if (Scan_Sig == 6'b111110) begin
                n_vec++;
                if (SMG_Data !== 8'hC0) begin n_bad++; $display("FAIL rstmid_digit0 got=%h exp=c0", SMG_Data); end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_midframe_load();
        test_lz();
        test_bright();
        test_load_at_frame_end();
        test_random();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
